// File: rtl/linebuffer_3x3_ctrl.sv
// linebuffer_3x3_ctrl
//   Sequences a linebuffer_3x3 instance for one feature-map frame. It accepts a
//   raster-order pixel stream, gates the line-buffer shift, and tracks the row and
//   column of each accepted pixel. It flags when ifmap_3x3 holds a complete 3x3
//   window that does not wrap across a row boundary. The input stream is held off
//   while the downstream PE array back-pressures a pending window.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         1-cycle frame start pulse (only honoured in IDLE)
//   cfg_height    frame rows, latched on an accepted start
//   s_valid/s_data/s_ready   pixel stream in (valid/ready)
//   lb_shift_en, lb_din      shift strobe and pixel to the line buffer
//   win_valid/win_ready      window handshake to the PE array
//   win_row, win_col         top-left coordinate of the current window
//   busy          frame in progress (RUN, DRAIN, DONE)
//   done          1-cycle pulse when the frame completes
module linebuffer_3x3_ctrl #(
    parameter int DATA_W    = 16,
    parameter int IMG_W     = 28,
    parameter int IMG_H_MAX = 28
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(IMG_H_MAX+1)-1:0] cfg_height,
    input  logic                           s_valid,
    input  logic [DATA_W-1:0]              s_data,
    output logic                           s_ready,
    output logic                           lb_shift_en,
    output logic [DATA_W-1:0]              lb_din,
    output logic                           win_valid,
    input  logic                           win_ready,
    output logic [$clog2(IMG_H_MAX)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]       win_col,
    output logic                           busy,
    output logic                           done
);

    localparam int HW = $clog2(IMG_H_MAX + 1);
    localparam int RW = $clog2(IMG_H_MAX);
    localparam int CW = $clog2(IMG_W);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t         state;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [RW-1:0]  h_last;
    logic [HW-1:0]  h_eff;
    logic           accept;
    logic           completing;
    logic           last_pix;

    // Heights above IMG_H_MAX are clamped so the row counter cannot overflow.
    always_comb begin
        h_eff = (cfg_height > HW'(IMG_H_MAX)) ? HW'(IMG_H_MAX) : cfg_height;
    end

    // A pending window that the PE array has not taken blocks the stream, so the
    // line-buffer contents behind win_valid stay stable.
    always_comb begin
        s_ready     = (state == RUN) && !(win_valid && !win_ready);
        accept      = s_valid && s_ready;
        lb_shift_en = accept;
        lb_din      = s_data;
        completing  = (row >= RW'(2)) && (col >= CW'(2));
        last_pix    = (row == h_last) && (col == COL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            h_last    <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= last_pix ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            // A new completing pixel in the same cycle as a handshake keeps
            // win_valid high and replaces the coordinates.
            if (accept && completing) begin
                win_valid <= 1'b1;
                win_row   <= row - RW'(2);
                win_col   <= col - CW'(2);
            end else if (win_valid && win_ready) begin
                win_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        row  <= '0;
                        col  <= '0;
                        busy <= 1'b1;
                        if (h_eff >= HW'(3)) begin
                            h_last <= RW'(h_eff - HW'(1));
                            state  <= RUN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept && last_pix) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!win_valid || win_ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
